// File: rtl/hp_rd_if.sv
// hp_rd_if: AXI read address/data channel bundle between the arbiter (master) and the HP port (slave)
//   ar_valid/ar_addr/ar_len/ar_ready : read address channel
//   r_valid/r_data/r_last/r_ready    : read data channel
interface hp_rd_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic              ar_valid;
  logic [ADDR_W-1:0] ar_addr;
  logic [7:0]        ar_len;
  logic              ar_ready;
  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic              r_last;
  logic              r_ready;
  modport master (output ar_valid, ar_addr, ar_len, r_ready, input ar_ready, r_valid, r_data, r_last);
  modport slave (input ar_valid, ar_addr, ar_len, r_ready, output ar_ready, r_valid, r_data, r_last);
endinterface

// File: rtl/hp_rd_arbiter.sv
// hp_rd_arbiter: round-robin sharing of one HP AXI read channel among NUM_REQ BRAM staging buffers
//   clk, rst_n       : clock, synchronous active-low reset
//   req/req_addr/req_len : per-requester level request, burst start address, burst length in beats
//   done             : one-cycle pulse when that requester's burst has finished
//   busy, err        : FSM not idle; sticky protocol error (zero length or r_last/length mismatch)
//   hp               : AXI AR/R channel toward the HP port
//   buf_valid/buf_data/buf_cnt/buf_full : beat routing into the granted buffer
module hp_rd_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int LEN_W   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len,
  output logic [NUM_REQ-1:0]        done,
  output logic                      busy,
  output logic                      err,
  hp_rd_if.master                   hp,
  output logic [NUM_REQ-1:0]        buf_valid,
  output logic [DATA_W-1:0]         buf_data,
  output logic [LEN_W-1:0]          buf_cnt,
  input  logic [NUM_REQ-1:0]        buf_full
);
  localparam int GW = $clog2(NUM_REQ);
  localparam logic [1:0] IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2;
  logic [1:0]        state;
  logic [GW-1:0]     g, rr_ptr, sel;
  logic [GW:0]       idx;
  logic              found;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q, sel_len;
  logic [LEN_W:0]    beat_cnt;
  logic [NUM_REQ-1:0] avail;
  logic              acc, is_last, fin;
  function automatic logic [GW-1:0] inc(input logic [GW-1:0] x);
    return x == GW'(NUM_REQ - 1) ? '0 : x + GW'(1);
  endfunction
  // a requester whose done pulse is showing cannot win the scan in the same cycle
  assign avail = req & ~done;
  always_comb begin
    found = 1'b0;
    sel = '0;
    idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_ptr} + (GW+1)'(k);
      idx = idx >= (GW+1)'(NUM_REQ) ? idx - (GW+1)'(NUM_REQ) : idx;
      if (!found && avail[idx[GW-1:0]]) begin
        found = 1'b1;
        sel = idx[GW-1:0];
      end
    end
  end
  assign sel_len = req_len[int'(sel)*LEN_W +: LEN_W];
  assign acc = state == DATA && hp.r_valid && !buf_full[g];
  assign is_last = beat_cnt == {1'b0, len_q} - (LEN_W+1)'(1);
  assign fin = acc && (is_last || hp.r_last);
  assign hp.ar_valid = state == ADDR;
  assign hp.ar_addr = addr_q;
  assign hp.ar_len = len_q == '0 ? 8'd0 : 8'(len_q) - 8'd1;
  assign hp.r_ready = state == DATA && !buf_full[g];
  assign buf_valid = acc ? NUM_REQ'(1) << g : '0;
  assign buf_data = hp.r_data;
  assign buf_cnt = len_q;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      g <= '0;
      rr_ptr <= '0;
      addr_q <= '0;
      len_q <= '0;
      beat_cnt <= '0;
      done <= '0;
      err <= 1'b0;
    end else begin
      done <= '0;
      case (state)
        IDLE: if (found) begin
          g <= sel;
          addr_q <= req_addr[int'(sel)*ADDR_W +: ADDR_W];
          len_q <= sel_len;
          // zero-length request: retire it immediately without touching the bus
          if (sel_len == '0) begin
            done <= NUM_REQ'(1) << sel;
            err <= 1'b1;
            rr_ptr <= inc(sel);
          end else state <= ADDR;
        end
        ADDR: if (hp.ar_ready) begin
          state <= DATA;
          beat_cnt <= '0;
        end
        DATA: if (acc) begin
          beat_cnt <= beat_cnt + (LEN_W+1)'(1);
          if (hp.r_last != is_last) err <= 1'b1;
          // whichever of r_last or the beat count comes first ends the burst
          if (fin) begin
            state <= IDLE;
            done <= NUM_REQ'(1) << g;
            rr_ptr <= inc(g);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
